// File: rtl/digital_crown_encoder.sv
// Digital crown quadrature front end: synchronises and debounces the two crown contacts,
// decodes full detents and keeps the wrapping 10-bit crown position.
module digital_crown_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int STEP            = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       En,
    input  logic       crown_a,
    input  logic       crown_b,
    input  logic       crown_clr,
    output logic [9:0] DigitalCrownValue,
    output logic       step_up,
    output logic       step_dn,
    output logic [2:0] sector
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [9:0]  STEP_W  = 10'(STEP);

    typedef enum logic [2:0] {
        DETENT, CW1, CW2, CW3, CCW1, CCW2, CCW3, ERR
    } state_t;

    logic        a_p0, a_p1, b_p0, b_p1, clr_p0, clr_p1;
    logic        deb_a_p2, deb_b_p2;
    logic [15:0] cnt_a, cnt_b;
    state_t      state, state_nxt;
    logic        up_evt, dn_evt;
    logic [1:0]  ab;

    function automatic logic [9:0] wrap_add(input logic [9:0] v, input logic [9:0] s);
        return v + s;
    endfunction

    function automatic logic [9:0] wrap_sub(input logic [9:0] v, input logic [9:0] s);
        return v - s;
    endfunction

    // Stage p0/p1: two-flop synchronisers, idle levels at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p0   <= 1'b1;
            a_p1   <= 1'b1;
            b_p0   <= 1'b1;
            b_p1   <= 1'b1;
            clr_p0 <= 1'b0;
            clr_p1 <= 1'b0;
        end else begin
            a_p0   <= crown_a;
            a_p1   <= a_p0;
            b_p0   <= crown_b;
            b_p1   <= b_p0;
            clr_p0 <= crown_clr;
            clr_p1 <= clr_p0;
        end
    end

    // Stage p2: per-channel debounce; a level must persist DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_a_p2 <= 1'b1;
            cnt_a    <= '0;
        end else if (a_p1 == deb_a_p2) begin
            cnt_a <= '0;
        end else if (cnt_a == DB_LAST) begin
            deb_a_p2 <= a_p1;
            cnt_a    <= '0;
        end else begin
            cnt_a <= cnt_a + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_b_p2 <= 1'b1;
            cnt_b    <= '0;
        end else if (b_p1 == deb_b_p2) begin
            cnt_b <= '0;
        end else if (cnt_b == DB_LAST) begin
            deb_b_p2 <= b_p1;
            cnt_b    <= '0;
        end else begin
            cnt_b <= cnt_b + 16'd1;
        end
    end

    assign ab = {deb_a_p2, deb_b_p2};

    always_comb begin
        state_nxt = state;
        up_evt    = 1'b0;
        dn_evt    = 1'b0;
        case (state)
            DETENT: case (ab)
                2'b01: state_nxt = CW1;
                2'b10: state_nxt = CCW1;
                2'b00: state_nxt = ERR;
                default: state_nxt = DETENT;
            endcase
            CW1: case (ab)
                2'b00: state_nxt = CW2;
                2'b11: state_nxt = DETENT;
                2'b10: state_nxt = ERR;
                default: state_nxt = CW1;
            endcase
            CW2: case (ab)
                2'b10: state_nxt = CW3;
                2'b01: state_nxt = CW1;
                2'b11: state_nxt = ERR;
                default: state_nxt = CW2;
            endcase
            CW3: case (ab)
                2'b11: begin state_nxt = DETENT; up_evt = 1'b1; end
                2'b00: state_nxt = CW2;
                2'b01: state_nxt = ERR;
                default: state_nxt = CW3;
            endcase
            CCW1: case (ab)
                2'b00: state_nxt = CCW2;
                2'b11: state_nxt = DETENT;
                2'b01: state_nxt = ERR;
                default: state_nxt = CCW1;
            endcase
            CCW2: case (ab)
                2'b01: state_nxt = CCW3;
                2'b10: state_nxt = CCW1;
                2'b11: state_nxt = ERR;
                default: state_nxt = CCW2;
            endcase
            CCW3: case (ab)
                2'b11: begin state_nxt = DETENT; dn_evt = 1'b1; end
                2'b00: state_nxt = CCW2;
                2'b10: state_nxt = ERR;
                default: state_nxt = CCW3;
            endcase
            default: state_nxt = (ab == 2'b11) ? DETENT : ERR;
        endcase
    end

    // Stage p3: quadrature state, position and one-cycle step pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= DETENT;
            DigitalCrownValue <= '0;
            step_up           <= 1'b0;
            step_dn           <= 1'b0;
        end else begin
            state   <= state_nxt;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            if (clr_p1) begin
                DigitalCrownValue <= '0;
            end else if (En && up_evt) begin
                DigitalCrownValue <= wrap_add(DigitalCrownValue, STEP_W);
                step_up           <= 1'b1;
            end else if (En && dn_evt) begin
                DigitalCrownValue <= wrap_sub(DigitalCrownValue, STEP_W);
                step_dn           <= 1'b1;
            end
        end
    end

    assign sector = DigitalCrownValue[9:7];

endmodule

// File: tb/tb_digital_crown_encoder.sv
// Directed bench for digital_crown_encoder with DEBOUNCE_CYCLES=4, STEP=16.
module tb_digital_crown_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       En = 1'b1;
    logic       crown_a = 1'b1;
    logic       crown_b = 1'b1;
    logic       crown_clr = 1'b0;
    logic [9:0] DigitalCrownValue;
    logic       step_up, step_dn;
    logic [2:0] sector;

    int n_tests = 0;
    int n_fail  = 0;
    int up_cnt  = 0;
    int dn_cnt  = 0;
    int both_cnt = 0;

    localparam logic [7:0] CW  = 8'b01_00_10_11;
    localparam logic [7:0] CCW = 8'b10_00_01_11;

    typedef struct {
        logic [7:0] seq;
        int         len;
        logic       en;
        int         exp_val;
        int         exp_up;
        int         exp_dn;
    } vec_t;

    vec_t tbl[9];

    digital_crown_encoder #(.DEBOUNCE_CYCLES(4), .STEP(16)) dut (
        .clk(clk), .rst_n(rst_n), .En(En), .crown_a(crown_a), .crown_b(crown_b),
        .crown_clr(crown_clr), .DigitalCrownValue(DigitalCrownValue),
        .step_up(step_up), .step_dn(step_dn), .sector(sector)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_up) up_cnt++;
        if (step_dn) dn_cnt++;
        if (step_up && step_dn) both_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic hold(input logic [1:0] lvl, input int n);
        crown_a = lvl[1];
        crown_b = lvl[0];
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_seq(input logic [7:0] seq, input int len);
        for (int j = 0; j < len; j++) hold(seq[7-2*j -: 2], 10);
    endtask

    initial begin
        int up0, dn0, lat;
        tbl[0] = '{CCW, 4, 1'b1, 0, 0, 1};
        tbl[1] = '{CCW, 4, 1'b1, 1008, 0, 1};
        tbl[2] = '{CW, 4, 1'b1, 0, 1, 0};
        tbl[3] = '{8'b01_11_00_00, 2, 1'b1, 0, 0, 0};
        tbl[4] = '{8'b00_10_11_00, 3, 1'b1, 0, 0, 0};
        tbl[5] = '{CW, 4, 1'b0, 0, 0, 0};
        tbl[6] = '{CW, 4, 1'b1, 16, 1, 0};
        tbl[7] = '{CW, 4, 1'b1, 32, 1, 0};
        tbl[8] = '{CW, 4, 1'b1, 48, 1, 0};

        repeat (3) @(negedge clk);
        chk("reset_value", int'(DigitalCrownValue), 0);
        chk("reset_pulses", int'({step_up, step_dn}), 0);
        chk("reset_sector", int'(sector), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single CW detent with exact pulse latency
        up0 = up_cnt;
        lat = 0;
        drive_seq(CW, 3);
        crown_a = 1'b1;
        crown_b = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (step_up && lat == 0) lat = k;
        end
        chk("cw_latency", lat, 7);
        chk("cw_pulses", up_cnt - up0, 1);
        chk("cw_value", int'(DigitalCrownValue), 16);
        chk("cw_sector", int'(sector), 0);

        for (int i = 0; i < 9; i++) begin
            up0 = up_cnt;
            dn0 = dn_cnt;
            En = tbl[i].en;
            drive_seq(tbl[i].seq, tbl[i].len);
            En = 1'b1;
            chk($sformatf("row%0d_value", i), int'(DigitalCrownValue), tbl[i].exp_val);
            chk($sformatf("row%0d_sector", i), int'(sector), tbl[i].exp_val >> 7);
            chk($sformatf("row%0d_up", i), up_cnt - up0, tbl[i].exp_up);
            chk($sformatf("row%0d_dn", i), dn_cnt - dn0, tbl[i].exp_dn);
        end

        // clear synchronised in the same cycle as an up event
        up0 = up_cnt;
        drive_seq(CW, 3);
        crown_a = 1'b1;
        crown_b = 1'b1;
        repeat (4) @(negedge clk);
        crown_clr = 1'b1;
        repeat (10) @(negedge clk);
        chk("clr_value", int'(DigitalCrownValue), 0);
        chk("clr_no_pulse", up_cnt - up0, 0);
        crown_clr = 1'b0;
        repeat (5) @(negedge clk);
        chk("clr_release_value", int'(DigitalCrownValue), 0);

        // clear latency from a nonzero value
        drive_seq(CW, 4);
        chk("pre_clr_value", int'(DigitalCrownValue), 16);
        crown_clr = 1'b1;
        repeat (4) @(negedge clk);
        chk("clr_latency", int'(DigitalCrownValue), 0);
        crown_clr = 1'b0;
        repeat (3) @(negedge clk);

        // reset mid-sequence
        drive_seq(CW, 4);
        drive_seq(CW, 4);
        drive_seq(8'b01_00_00_00, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_value", int'(DigitalCrownValue), 0);
        chk("rst_mid_pulses", int'({step_up, step_dn}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        up0 = up_cnt;
        dn0 = dn_cnt;
        hold(2'b00, 10);
        drive_seq(8'b10_11_00_00, 2);
        chk("rst_after_value", int'(DigitalCrownValue), 0);
        chk("rst_after_pulses", (up_cnt - up0) + (dn_cnt - dn0), 0);

        // wrap down then 64 detents back around
        dn0 = dn_cnt;
        drive_seq(CCW, 4);
        chk("wrap_dn_value", int'(DigitalCrownValue), 1008);
        chk("wrap_dn_sector", int'(sector), 7);
        chk("wrap_dn_pulse", dn_cnt - dn0, 1);
        up0 = up_cnt;
        for (int i = 0; i < 64; i++) drive_seq(CW, 4);
        chk("wrap64_value", int'(DigitalCrownValue), 1008);
        chk("wrap64_pulses", up_cnt - up0, 64);

        // 2-cycle glitch on A at rest is ignored
        up0 = up_cnt;
        dn0 = dn_cnt;
        hold(2'b01, 2);
        hold(2'b11, 12);
        chk("glitch_value", int'(DigitalCrownValue), 1008);
        chk("glitch_pulses", (up_cnt - up0) + (dn_cnt - dn0), 0);
        drive_seq(CW, 4);
        chk("glitch_then_cw", int'(DigitalCrownValue), 0);
        chk("glitch_then_cw_up", up_cnt - up0, 1);

        chk("never_both_pulses", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
